cmd_sequencer: RTL and testbench
================================

Name: cmd_sequencer

Overview:
- Fetch/issue controller for the byte-coded command set: MOV, ADD, CMP, JMP, JEQ and JGG, plus a sequencer-only HLT.
- Fetches opcode and operand bytes from byte-wide program memory and decodes opcode size and flags.
- Issues MOV/ADD/CMP to the execute datapath over a valid/ready handshake.
- Resolves jumps locally, using compare flags returned by the datapath.

Parameters:
ADDR_W, 8, program-counter and memory-address width; the PC wraps modulo 2^ADDR_W.
START_ADDR, 0, PC value loaded on start.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  one-cycle pulse; honoured only in IDLE or HALT.
mem_req  out  1  program-memory read request; held until mem_valid.
mem_addr  out  ADDR_W  read address; stable while mem_req=1.
mem_valid  in  1  read data valid; one cycle per request, no earlier than the cycle after mem_req rises.
mem_rdata  in  8  read byte; sampled when mem_valid=1.
exec_valid  out  1  command offered to the datapath.
exec_ready  in  1  datapath accepts the command when exec_valid & exec_ready.
exec_flags  out  6  one-hot {MOV,ADD,CMP,JMP,JEQ,JGG}; only MOV/ADD/CMP bits are ever issued.
exec_arg0  out  8  byte 1 of the command (MOV register); 0 for 1-byte commands.
exec_arg1  out  8  byte 2 of the command (MOV immediate); 0 otherwise.
flag_eq  in  1  datapath equal flag; must be valid from the cycle after a CMP handshake.
flag_gt  in  1  datapath greater flag; same timing as flag_eq.
pc  out  ADDR_W  address of the current command's opcode.
busy  out  1  high in every state except IDLE and HALT.
halted  out  1  high in HALT.
err_opcode  out  1  sticky: the last halt was caused by an unknown opcode.
retired  out  CNT_W  count of retired commands, wrapping modulo 2^CMD_W.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=START_ADDR, and every output 0: mem_req, mem_addr, exec_valid, exec_flags, exec_arg0/1, busy, halted, err_opcode, retired.
- Reset asserted mid-fetch or mid-issue aborts the operation immediately; no handshake completes.
- Opcode codes (decimal): MOV=77, ADD=65, CMP=67, JMP=74, JEQ=69, JGG=71, HLT=72.
- Command sizes in bytes: MOV 3, ADD 1, CMP 1, JMP/JEQ/JGG 2, HLT 1.
- Any other opcode is unknown: go to HALT with err_opcode=1.
- States: IDLE, FETCH_OP, FETCH_B1, FETCH_B2, ISSUE, JUMP, HALT.
- IDLE / HALT:
  - start=1 -> FETCH_OP, pc=START_ADDR, err_opcode cleared.
  - retired is NOT cleared by start.
- FETCH_OP:
  - mem_req=1, mem_addr=pc.
  - On mem_valid, latch the opcode, then go to:
    - FETCH_B1 if size >= 2;
    - ISSUE for ADD/CMP;
    - HALT for HLT (retired+1);
    - HALT for unknown (err_opcode=1, retired unchanged).
- FETCH_B1:
  - mem_addr=pc+1, with wrap.
  - On mem_valid, latch byte1, then go to FETCH_B2 (MOV) or JUMP (jumps).
- FETCH_B2:
  - mem_addr=pc+2, with wrap.
  - On mem_valid, latch byte2, then go to ISSUE.
- mem_req drops for at least the one cycle in which the state changes; no two requests are outstanding.
- ISSUE:
  - exec_valid=1; exec_flags/arg0/arg1 are registered and stable until the handshake.
  - On exec_valid & exec_ready: pc += size, retired+1, exec_valid=0 the next cycle, go to FETCH_OP.
  - exec_ready while not in ISSUE is ignored.
- JUMP (one cycle):
  - Taken = JMP, or JEQ & flag_eq, or JGG & flag_gt.
  - Taken: pc=byte1 (zero-extended or truncated to ADDR_W).
  - Not taken: pc+=2.
  - Either way retired+1, then FETCH_OP.
- A jump to its own address loops forever; this is not an error.
- Arithmetic: pc modulo 2^ADDR_W; operand addresses wrap past the top of memory.
- start while busy is ignored.
- mem_valid while mem_req=0 is ignored.

Test Plan:
1. Memory {77,3,9,65,72} at 0, 1-cycle memory, exec_ready tied 1, start pulse:
   - One MOV issue with flags 100000, arg0=3, arg1=9.
   - Then one ADD issue with flags 010000, args 0.
   - Then HALT: halted=1, retired=3, err_opcode=0, pc=4.
2. ISSUE backpressure: hold exec_ready=0 for 5 cycles on the MOV.
   - exec_valid stays 1 with flags and args unchanged.
   - pc is unchanged until ready; exactly one handshake occurs.
3. Jumps: program {67,69,6,72,0,0,72} with flag_eq=1 after CMP.
   - JEQ taken: pc=6, then HALT with retired=3.
   - Repeat with flag_eq=0: pc=3, then HALT with retired=3.
4. Unknown opcode 0x00 at START_ADDR:
   - HALT with err_opcode=1, retired=0, no exec_valid.
   - A following start clears err_opcode.
5. Wrap: JMP to 255 with ADDR_W=8; MOV at 255 fetches bytes from 0 and 1, then pc=2.
6. Assert rst_n=0 while in FETCH_B1 with mem_req=1:
   - mem_req, busy and exec_valid all drop before the next clock edge.
   - pc=START_ADDR, state=IDLE.

Source files
------------

// File: rtl/cmd_sequencer.sv
// Fetch/issue sequencer for the byte-coded MOV/ADD/CMP/JMP/JEQ/JGG/HLT command set.
// Fetches commands from byte-wide memory, issues data commands and resolves jumps locally.
module cmd_sequencer #(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = {ADDR_W{1'b0}},
    parameter int                CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [7:0]        mem_rdata,
    output logic              exec_valid,
    input  logic              exec_ready,
    output logic [5:0]        exec_flags,
    output logic [7:0]        exec_arg0,
    output logic [7:0]        exec_arg1,
    input  logic              flag_eq,
    input  logic              flag_gt,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              err_opcode,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH_OP = 3'd1,
        S_FETCH_B1 = 3'd2,
        S_FETCH_B2 = 3'd3,
        S_ISSUE    = 3'd4,
        S_JUMP     = 3'd5,
        S_HALT     = 3'd6
    } state_t;

    localparam logic [7:0] OP_MOV = 8'd77;
    localparam logic [7:0] OP_ADD = 8'd65;
    localparam logic [7:0] OP_CMP = 8'd67;
    localparam logic [7:0] OP_JMP = 8'd74;
    localparam logic [7:0] OP_JEQ = 8'd69;
    localparam logic [7:0] OP_JGG = 8'd71;
    localparam logic [7:0] OP_HLT = 8'd72;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(2'd1);
    localparam logic [ADDR_W-1:0] ADDR_TWO = ADDR_W'(2'd2);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1'b1);

    // Command length in bytes; zero marks an unknown opcode.
    function automatic logic [1:0] op_size(input logic [7:0] op);
        case (op)
            OP_MOV:                 op_size = 2'd3;
            OP_JMP, OP_JEQ, OP_JGG: op_size = 2'd2;
            OP_ADD, OP_CMP, OP_HLT: op_size = 2'd1;
            default:                op_size = 2'd0;
        endcase
    endfunction

    function automatic logic [5:0] op_flags(input logic [7:0] op);
        case (op)
            OP_MOV:  op_flags = 6'b100000;
            OP_ADD:  op_flags = 6'b010000;
            OP_CMP:  op_flags = 6'b001000;
            OP_JMP:  op_flags = 6'b000100;
            OP_JEQ:  op_flags = 6'b000010;
            OP_JGG:  op_flags = 6'b000001;
            default: op_flags = 6'b000000;
        endcase
    endfunction

    function automatic logic is_fetch(input state_t s);
        is_fetch = (s == S_FETCH_OP) || (s == S_FETCH_B1) || (s == S_FETCH_B2);
    endfunction

    state_t              state_r, state_s;
    logic [7:0]          op_r, op_s;
    logic [7:0]          b1_r, b1_s;
    logic [7:0]          b2_r, b2_s;
    logic [ADDR_W-1:0]   pc_r, pc_s;
    logic [CNT_W-1:0]    retired_r, retired_s;
    logic                err_r, err_s;
    logic                mem_req_r, mem_req_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic                exec_valid_r, exec_valid_s;
    logic [5:0]          exec_flags_r, exec_flags_s;
    logic [7:0]          arg0_r, arg0_s;
    logic [7:0]          arg1_r, arg1_s;
    logic                busy_r, busy_s;
    logic                halted_r, halted_s;
    logic                mem_fire_s;
    logic                exec_fire_s;
    logic                taken_s;

    // mem_req_r is only ever high in fetch states, so this qualifies stray mem_valid away
    assign mem_fire_s  = mem_req_r & mem_valid;
    assign exec_fire_s = exec_valid_r & exec_ready;

    // Jump condition evaluated in the single JUMP cycle
    always_comb begin
        case (op_r)
            OP_JMP:  taken_s = 1'b1;
            OP_JEQ:  taken_s = flag_eq;
            OP_JGG:  taken_s = flag_gt;
            default: taken_s = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE, S_HALT: begin
                if (start) state_s = S_FETCH_OP;
                else       state_s = state_r;
            end
            S_FETCH_OP: begin
                if (mem_fire_s) begin
                    case (mem_rdata)
                        OP_MOV, OP_JMP, OP_JEQ, OP_JGG: state_s = S_FETCH_B1;
                        OP_ADD, OP_CMP:                 state_s = S_ISSUE;
                        default:                        state_s = S_HALT;
                    endcase
                end else begin
                    state_s = state_r;
                end
            end
            S_FETCH_B1: begin
                if (mem_fire_s) state_s = (op_r == OP_MOV) ? S_FETCH_B2 : S_JUMP;
                else            state_s = state_r;
            end
            S_FETCH_B2: begin
                if (mem_fire_s) state_s = S_ISSUE;
                else            state_s = state_r;
            end
            S_ISSUE: begin
                if (exec_fire_s) state_s = S_FETCH_OP;
                else             state_s = state_r;
            end
            S_JUMP:  state_s = S_FETCH_OP;
            default: state_s = S_IDLE;
        endcase
    end

    // FSM output logic: next values for every registered output and datapath register
    always_comb begin
        op_s      = op_r;
        b1_s      = b1_r;
        b2_s      = b2_r;
        pc_s      = pc_r;
        retired_s = retired_r;
        err_s     = err_r;
        case (state_r)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_s  = START_ADDR;
                    err_s = 1'b0;
                end else begin
                    pc_s  = pc_r;
                    err_s = err_r;
                end
            end
            S_FETCH_OP: begin
                if (mem_fire_s) begin
                    op_s = mem_rdata;
                    b1_s = 8'd0;
                    b2_s = 8'd0;
                    if (mem_rdata == OP_HLT) begin
                        retired_s = retired_r + CNT_ONE;
                    end else if (op_size(mem_rdata) == 2'd0) begin
                        err_s = 1'b1;
                    end else begin
                        retired_s = retired_r;
                    end
                end else begin
                    op_s = op_r;
                end
            end
            S_FETCH_B1: begin
                if (mem_fire_s) b1_s = mem_rdata;
                else            b1_s = b1_r;
            end
            S_FETCH_B2: begin
                if (mem_fire_s) b2_s = mem_rdata;
                else            b2_s = b2_r;
            end
            S_ISSUE: begin
                if (exec_fire_s) begin
                    pc_s      = pc_r + ADDR_W'(op_size(op_r));
                    retired_s = retired_r + CNT_ONE;
                end else begin
                    pc_s      = pc_r;
                end
            end
            S_JUMP: begin
                if (taken_s) pc_s = ADDR_W'(b1_r);
                else         pc_s = pc_r + ADDR_TWO;
                retired_s = retired_r + CNT_ONE;
            end
            default: begin
                pc_s = pc_r;
            end
        endcase

        // A completing read forces one idle request cycle before the next fetch.
        mem_req_s = is_fetch(state_s) & ~mem_fire_s;
        case (state_s)
            S_FETCH_OP: mem_addr_s = pc_s;
            S_FETCH_B1: mem_addr_s = pc_s + ADDR_ONE;
            S_FETCH_B2: mem_addr_s = pc_s + ADDR_TWO;
            default:    mem_addr_s = {ADDR_W{1'b0}};
        endcase

        exec_valid_s = (state_s == S_ISSUE);
        if (exec_valid_s) begin
            exec_flags_s = op_flags(op_s);
            arg0_s       = b1_s;
            arg1_s       = b2_s;
        end else begin
            exec_flags_s = 6'd0;
            arg0_s       = 8'd0;
            arg1_s       = 8'd0;
        end

        busy_s   = (state_s != S_IDLE) && (state_s != S_HALT);
        halted_s = (state_s == S_HALT);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r         <= 8'd0;
            b1_r         <= 8'd0;
            b2_r         <= 8'd0;
            pc_r         <= START_ADDR;
            retired_r    <= {CNT_W{1'b0}};
            err_r        <= 1'b0;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            exec_valid_r <= 1'b0;
            exec_flags_r <= 6'd0;
            arg0_r       <= 8'd0;
            arg1_r       <= 8'd0;
            busy_r       <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            op_r         <= op_s;
            b1_r         <= b1_s;
            b2_r         <= b2_s;
            pc_r         <= pc_s;
            retired_r    <= retired_s;
            err_r        <= err_s;
            mem_req_r    <= mem_req_s;
            mem_addr_r   <= mem_addr_s;
            exec_valid_r <= exec_valid_s;
            exec_flags_r <= exec_flags_s;
            arg0_r       <= arg0_s;
            arg1_r       <= arg1_s;
            busy_r       <= busy_s;
            halted_r     <= halted_s;
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign exec_valid = exec_valid_r;
    assign exec_flags = exec_flags_r;
    assign exec_arg0  = arg0_r;
    assign exec_arg1  = arg1_r;
    assign pc         = pc_r;
    assign busy       = busy_r;
    assign halted     = halted_r;
    assign err_opcode = err_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Bench for cmd_sequencer: directed scenarios plus random programs checked against
// an instruction-level interpreter of the command set.
module tb_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_valid = 1'b0;
    logic [7:0]  mem_rdata = 8'd0;
    logic        exec_valid;
    logic        exec_ready = 1'b1;
    logic [5:0]  exec_flags;
    logic [7:0]  exec_arg0;
    logic [7:0]  exec_arg1;
    logic        flag_eq = 1'b0;
    logic        flag_gt = 1'b0;
    logic [7:0]  pc;
    logic        busy;
    logic        halted;
    logic        err_opcode;
    logic [15:0] retired;

    cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
        .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_flags(exec_flags),
        .exec_arg0(exec_arg0), .exec_arg1(exec_arg1),
        .flag_eq(flag_eq), .flag_gt(flag_gt),
        .pc(pc), .busy(busy), .halted(halted), .err_opcode(err_opcode), .retired(retired)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  mem [256];
    int          mem_lat = 1;
    bit          noise = 1'b0;
    bit          rand_ready = 1'b0;
    int          ready_hold = 0;
    int          wait_cnt = 0;
    logic [29:0] hs_q[$];   // {pc, flags, arg0, arg1} of every accepted command

    // Reference model results
    logic [29:0] exp_q[$];
    logic [7:0]  exp_pc;
    int          exp_ret;
    bit          exp_err;
    bit          exp_halts;

    // Memory responder, datapath ready driver and handshake recorder
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_valid = 1'b0;
            wait_cnt  = 0;
        end else if (mem_valid) begin
            mem_valid = 1'b0;
            wait_cnt  = 0;
        end else if (mem_req) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
                mem_valid = 1'b1;
                mem_rdata = mem[mem_addr];
            end
        end else begin
            wait_cnt = 0;
            if (noise && $urandom_range(0, 3) == 0) begin
                mem_valid = 1'b1;
                mem_rdata = 8'($urandom);
            end
        end
        if (exec_valid && ready_hold > 0) begin
            exec_ready = 1'b0;
            ready_hold--;
        end else if (rand_ready) begin
            exec_ready = ($urandom_range(0, 2) != 0);
        end else begin
            exec_ready = 1'b1;
        end
        if (rst_n && exec_valid && exec_ready)
            hs_q.push_back({pc, exec_flags, exec_arg0, exec_arg1});
    end

    // Instruction-level interpreter: runs the program in mem from address 0.
    task automatic model_run(input bit feq, input bit fgt);
        logic [7:0] p, p1, p2, op;
        exp_q.delete();
        exp_ret   = 0;
        exp_err   = 1'b0;
        exp_halts = 1'b0;
        p = 8'd0;
        for (int n = 0; n < 120; n++) begin
            if (exp_halts) break;
            op = mem[p];
            p1 = p + 8'd1;
            p2 = p + 8'd2;
            case (op)
                8'd77: begin exp_q.push_back({p, 6'b100000, mem[p1], mem[p2]}); p = p + 8'd3; exp_ret++; end
                8'd65: begin exp_q.push_back({p, 6'b010000, 8'd0, 8'd0}); p = p + 8'd1; exp_ret++; end
                8'd67: begin exp_q.push_back({p, 6'b001000, 8'd0, 8'd0}); p = p + 8'd1; exp_ret++; end
                8'd74: begin p = mem[p1]; exp_ret++; end
                8'd69: begin p = feq ? mem[p1] : p2; exp_ret++; end
                8'd71: begin p = fgt ? mem[p1] : p2; exp_ret++; end
                8'd72: begin exp_ret++; exp_halts = 1'b1; end
                default: begin exp_err = 1'b1; exp_halts = 1'b1; end
            endcase
        end
        exp_pc = p;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
    endtask

    task automatic load_basic();
        clear_mem();
        mem[0] = 8'd77; mem[1] = 8'd3; mem[2] = 8'd9; mem[3] = 8'd65; mem[4] = 8'd72;
    endtask

    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk); #1;
            if (halted) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL halt_timeout: halted=%0b, required 1 within %0d cycles", halted, budget);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, exec_valid, busy, halted, err_opcode} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: {req,valid,busy,halted,err}=%b, required 00000",
                     {mem_req, exec_valid, busy, halted, err_opcode});
        end
        checks++;
        if ({mem_addr, exec_flags, exec_arg0, exec_arg1} !== 30'd0) begin
            errors++;
            $display("FAIL reset_bus: addr/flags/args=%h, required 0",
                     {mem_addr, exec_flags, exec_arg0, exec_arg1});
        end
        checks++;
        if (pc !== 8'd0 || retired !== 16'd0) begin
            errors++;
            $display("FAIL reset_pc_ret: pc=%0d retired=%0d, required 0 0", pc, retired);
        end
        do_reset();
    endtask

    task automatic test_basic();
        bit ok;
        do_reset();
        load_basic();
        mem_lat = 1; rand_ready = 1'b0; noise = 1'b0; ready_hold = 0;
        hs_q.delete();
        start_pulse();
        wait_halt(200, ok);
        checks++;
        if (hs_q.size() !== 2) begin
            errors++; $display("FAIL basic_count: handshakes=%0d, required 2", hs_q.size());
        end
        checks++;
        if (hs_q.size() < 1 || hs_q[0] !== {8'd0, 6'b100000, 8'd3, 8'd9}) begin
            errors++; $display("FAIL basic_mov: got %h, required %h",
                               (hs_q.size() > 0) ? hs_q[0] : 30'h0, {8'd0, 6'b100000, 8'd3, 8'd9});
        end
        checks++;
        if (hs_q.size() < 2 || hs_q[1] !== {8'd3, 6'b010000, 8'd0, 8'd0}) begin
            errors++; $display("FAIL basic_add: got %h, required %h",
                               (hs_q.size() > 1) ? hs_q[1] : 30'h0, {8'd3, 6'b010000, 8'd0, 8'd0});
        end
        checks++;
        if ({halted, busy, err_opcode} !== 3'b100 || retired !== 16'd3 || pc !== 8'd4) begin
            errors++; $display("FAIL basic_halt: halted=%0b busy=%0b err=%0b retired=%0d pc=%0d, required 1 0 0 3 4",
                               halted, busy, err_opcode, retired, pc);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit found;
        logic [29:0] held;
        do_reset();
        load_basic();
        hs_q.delete();
        ready_hold = 5;
        start_pulse();
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (exec_valid) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL bp_offer: exec_valid=%0b, required 1 within 50 cycles", exec_valid);
        end
        held = {pc, exec_flags, exec_arg0, exec_arg1};
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (k == 0) start = 1'b1;
            if (k == 1) start = 1'b0;
            checks++;
            if (!exec_valid || exec_ready || {pc, exec_flags, exec_arg0, exec_arg1} !== held) begin
                errors++; $display("FAIL bp_hold[%0d]: valid=%0b ready=%0b cmd=%h, required 1 0 %h",
                                   k, exec_valid, exec_ready, {pc, exec_flags, exec_arg0, exec_arg1}, held);
            end
        end
        wait_halt(200, ok);
        checks++;
        if (hs_q.size() !== 2 || hs_q[0] !== {8'd0, 6'b100000, 8'd3, 8'd9} || retired !== 16'd3 || pc !== 8'd4) begin
            errors++; $display("FAIL bp_result: handshakes=%0d first=%h retired=%0d pc=%0d, required 2 %h 3 4",
                               hs_q.size(), (hs_q.size() > 0) ? hs_q[0] : 30'h0,
                               {8'd0, 6'b100000, 8'd3, 8'd9}, retired, pc);
        end
    endtask

    task automatic test_jumps();
        bit ok;
        for (int f = 1; f >= 0; f--) begin
            do_reset();
            clear_mem();
            mem[0] = 8'd67; mem[1] = 8'd69; mem[2] = 8'd6; mem[3] = 8'd72; mem[6] = 8'd72;
            flag_eq = f[0];
            hs_q.delete();
            start_pulse();
            wait_halt(200, ok);
            checks++;
            if (pc !== (f ? 8'd6 : 8'd3) || retired !== 16'd3 || err_opcode !== 1'b0) begin
                errors++; $display("FAIL jeq_eq%0d: pc=%0d retired=%0d err=%0b, required %0d 3 0",
                                   f, pc, retired, err_opcode, f ? 6 : 3);
            end
            checks++;
            if (hs_q.size() !== 1 || hs_q[0] !== {8'd0, 6'b001000, 8'd0, 8'd0}) begin
                errors++; $display("FAIL jeq_cmp%0d: handshakes=%0d, required 1 CMP", f, hs_q.size());
            end
        end
        flag_eq = 1'b0;
    endtask

    task automatic test_unknown();
        bit ok;
        do_reset();
        clear_mem();
        hs_q.delete();
        start_pulse();
        wait_halt(200, ok);
        checks++;
        if (err_opcode !== 1'b1 || retired !== 16'd0 || hs_q.size() !== 0 || pc !== 8'd0) begin
            errors++; $display("FAIL unknown_halt: err=%0b retired=%0d handshakes=%0d pc=%0d, required 1 0 0 0",
                               err_opcode, retired, hs_q.size(), pc);
        end
        start_pulse();
        checks++;
        if (err_opcode !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL unknown_restart: err=%0b busy=%0b, required 0 1", err_opcode, busy);
        end
        wait_halt(200, ok);
        checks++;
        if (err_opcode !== 1'b1) begin
            errors++; $display("FAIL unknown_again: err=%0b, required 1", err_opcode);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        do_reset();
        clear_mem();
        mem[0] = 8'd74; mem[1] = 8'd255; mem[2] = 8'd72; mem[255] = 8'd77;
        hs_q.delete();
        start_pulse();
        wait_halt(200, ok);
        checks++;
        if (hs_q.size() !== 1 || hs_q[0] !== {8'd255, 6'b100000, 8'd74, 8'd255}) begin
            errors++; $display("FAIL wrap_mov: handshakes=%0d first=%h, required 1 %h", hs_q.size(),
                               (hs_q.size() > 0) ? hs_q[0] : 30'h0, {8'd255, 6'b100000, 8'd74, 8'd255});
        end
        checks++;
        if (pc !== 8'd2 || retired !== 16'd3) begin
            errors++; $display("FAIL wrap_pc: pc=%0d retired=%0d, required 2 3", pc, retired);
        end
    endtask

    task automatic test_reset_mid_fetch();
        bit found;
        do_reset();
        load_basic();
        mem_lat = 3;
        hs_q.delete();
        start_pulse();
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(posedge clk); #1;
            if (mem_req && mem_addr == 8'd1) begin found = 1'b1; break; end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL midrst_reach: mem_req=%0b addr=%0d, required 1 1", mem_req, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, busy, exec_valid, halted} !== 4'b0 || pc !== 8'd0) begin
            errors++; $display("FAIL midrst_drop: {req,busy,valid,halted}=%b pc=%0d, required 0000 0",
                               {mem_req, busy, exec_valid, halted}, pc);
        end
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || mem_req !== 1'b0 || hs_q.size() !== 0) begin
            errors++; $display("FAIL midrst_idle: busy=%0b req=%0b handshakes=%0d, required 0 0 0",
                               busy, mem_req, hs_q.size());
        end
        mem_lat = 1;
    endtask

    task automatic test_random();
        bit ok;
        bit feq, fgt;
        logic [7:0] ops [7] = '{8'd77, 8'd65, 8'd67, 8'd74, 8'd69, 8'd71, 8'd72};
        logic [15:0] base;
        int r;
        for (int it = 0; it < 10; it++) begin
            feq = 1'($urandom);
            fgt = 1'($urandom);
            for (int t = 0; t < 20; t++) begin
                for (int i = 0; i < 256; i++) begin
                    r = $urandom_range(0, 7);
                    mem[i] = (r == 7) ? 8'($urandom) : ops[r];
                end
                model_run(feq, fgt);
                if (exp_halts) break;
            end
            if (!exp_halts) begin
                mem[0] = 8'd72;
                model_run(feq, fgt);
            end
            flag_eq = feq; flag_gt = fgt;
            mem_lat = $urandom_range(1, 3);
            noise = 1'b1; rand_ready = 1'b1;
            base = retired;
            hs_q.delete();
            start_pulse();
            wait_halt(6000, ok);
            checks++;
            if (hs_q.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count: handshakes=%0d, required %0d", it, hs_q.size(), exp_q.size());
            end
            for (int k = 0; k < exp_q.size() && k < hs_q.size(); k++) begin
                checks++;
                if (hs_q[k] !== exp_q[k]) begin
                    errors++; $display("FAIL rand%0d_cmd%0d: got %h, required %h", it, k, hs_q[k], exp_q[k]);
                end
            end
            checks++;
            if (pc !== exp_pc || retired !== base + 16'(exp_ret) || err_opcode !== exp_err) begin
                errors++; $display("FAIL rand%0d_end: pc=%0d retired=%0d err=%0b, required %0d %0d %0b",
                                   it, pc, retired, err_opcode, exp_pc, base + 16'(exp_ret), exp_err);
            end
        end
        noise = 1'b0; rand_ready = 1'b0; mem_lat = 1;
        flag_eq = 1'b0; flag_gt = 1'b0;
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_basic();
        test_backpressure();
        test_jumps();
        test_unknown();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
